// File: rtl/m_reduce_pkg.sv
// m_reduce_pkg: mode encodings and elaboration helpers shared by the reduction tree and its bench.
package m_reduce_pkg;
    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_NOR = 2'b11;

    function automatic int f_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int f_num_stages(input int levels, input int reg_every);
        return (levels + reg_every - 1) / reg_every;
    endfunction
endpackage

// File: rtl/m_reduce_level.sv
// m_reduce_level: one combinational tree level folding IN_W bits into IN_W/2 with the mode operator.
// With M_REDUCE_IDX_EN it also folds (hit, idx) pairs, the left (lower) child winning when it has a hit.
module m_reduce_level
    import m_reduce_pkg::*;
#(
    parameter int IN_W = 2
`ifdef M_REDUCE_IDX_EN
    , parameter int IW = 1
`endif
) (
    input  logic [IN_W-1:0]      bits,
    input  logic [1:0]           mode,
    output logic [IN_W/2-1:0]    y
`ifdef M_REDUCE_IDX_EN
    , input  logic [IN_W-1:0]    hits,
    input  logic [IN_W*IW-1:0]   idxs,
    output logic [IN_W/2-1:0]    hit,
    output logic [IN_W/2*IW-1:0] idx
`endif
);
    genvar i;
    for (i = 0; i < IN_W / 2; i++) begin : g_node
        logic l, r;
        assign l = bits[2*i];
        assign r = bits[2*i+1];
        // NOR folds as OR; the inversion is applied once at the output
        assign y[i] = (mode == MODE_AND) ? (l & r) : (mode == MODE_XOR) ? (l ^ r) : (l | r);
`ifdef M_REDUCE_IDX_EN
        assign hit[i] = hits[2*i] | hits[2*i+1];
        assign idx[i*IW +: IW] = hits[2*i] ? idxs[2*i*IW +: IW] : idxs[(2*i+1)*IW +: IW];
`endif
    end
endmodule

// File: rtl/m_reduce_pipe.sv
// m_reduce_pipe: pipelined OR/AND/XOR/NOR reduction tree, registered every REG_EVERY levels, valid/ready.
// Define M_REDUCE_IDX_EN to add o_idx, the lowest set-bit index of the accepted word.
module m_reduce_pipe
    import m_reduce_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [1:0]       i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_out
`ifdef M_REDUCE_IDX_EN
    , output logic [f_clog2(WIDTH)-1:0] o_idx
`endif
);
    localparam int LEVELS = f_clog2(WIDTH);
`ifdef M_REDUCE_IDX_EN
    localparam int IW = LEVELS;
`endif
    logic en;
    assign en = !o_valid || i_ready;
    assign o_ready = en;

    genvar k;
    for (k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IN_W  = WIDTH >> k;
        localparam int OUT_W = IN_W / 2;
        localparam bit REG   = ((k + 1) % REG_EVERY == 0) || (k == LEVELS - 1);
        logic [IN_W-1:0]  a;
        logic [1:0]       md;
        logic             va;
        logic [OUT_W-1:0] y, q;
        logic [1:0]       qm;
        logic             qv;
`ifdef M_REDUCE_IDX_EN
        logic [IN_W-1:0]     ha;
        logic [IN_W*IW-1:0]  xa;
        logic [OUT_W-1:0]    hy, qh;
        logic [OUT_W*IW-1:0] xy, qx;
`endif
        if (k == 0) begin : g_src
            assign a  = i_a;
            assign md = i_mode;
            assign va = i_valid;
`ifdef M_REDUCE_IDX_EN
            assign ha = i_a;
            always_comb
                for (int j = 0; j < WIDTH; j++) xa[j*IW +: IW] = IW'(j);
`endif
        end else begin : g_src
            assign a  = g_lvl[k-1].q;
            assign md = g_lvl[k-1].qm;
            assign va = g_lvl[k-1].qv;
`ifdef M_REDUCE_IDX_EN
            assign ha = g_lvl[k-1].qh;
            assign xa = g_lvl[k-1].qx;
`endif
        end

        m_reduce_level #(
            .IN_W(IN_W)
`ifdef M_REDUCE_IDX_EN
            , .IW(IW)
`endif
        ) u_level (
            .bits(a),
            .mode(md),
            .y(y)
`ifdef M_REDUCE_IDX_EN
            , .hits(ha),
            .idxs(xa),
            .hit(hy),
            .idx(xy)
`endif
        );

        // the mode travels with its word so later levels never see a newer word's mode
        if (REG) begin : g_reg
            always_ff @(posedge i_clk or posedge i_rst)
                if (i_rst) begin
                    q  <= '0;
                    qm <= '0;
                    qv <= 1'b0;
`ifdef M_REDUCE_IDX_EN
                    qh <= '0;
                    qx <= '0;
`endif
                end else if (en) begin
                    qv <= va;
                    if (va) begin
                        q  <= y;
                        qm <= md;
`ifdef M_REDUCE_IDX_EN
                        qh <= hy;
                        qx <= xy;
`endif
                    end
                end
        end else begin : g_pass
            assign q  = y;
            assign qm = md;
            assign qv = va;
`ifdef M_REDUCE_IDX_EN
            assign qh = hy;
            assign qx = xy;
`endif
        end
    end

    assign o_valid = g_lvl[LEVELS-1].qv;
    assign o_out   = g_lvl[LEVELS-1].q[0] ^ (g_lvl[LEVELS-1].qm == MODE_NOR);
`ifdef M_REDUCE_IDX_EN
    assign o_idx   = g_lvl[LEVELS-1].qh[0] ? g_lvl[LEVELS-1].qx : '0;
`endif
endmodule
